alu_pipe_disp: RTL and testbench

ALU_PIPE_DISP -- requirements
Module: alu_pipe_disp

---
 rtl/alu_pipe_disp.sv | 179 +++++++++++++++++
 tb/tb_alu_pipe_disp.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_disp.sv
// alu_pipe_disp: single-cycle ALU with optional shift-add multiplier (ALU_MUL_EN) and a multiplexed hex display of the result
module alu_pipe_disp #(
  parameter int W            = 8,
  parameter int REFRESH_BITS = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [2:0]       op,
  output logic             out_valid,
  output logic [W-1:0]     result,
  output logic [3:0]       flags,
  output logic [6:0]       seg,
  output logic             dp,
  output logic [W/4-1:0]   an
);
  localparam int ND = W / 4;
  localparam int DB = $clog2(ND);
  localparam int SB = $clog2(W);

  logic             w_acc_ok, w_is_mul, w_done, w_mc;
  logic [W-1:0]     w_mres;
  logic             r_v;
  logic [W-1:0]     r_a, r_b;
  logic [2:0]       r_op;
  logic [W-1:0]     w_res, w_bb;
  logic             w_c, w_v;
  logic [W:0]       w_sum, w_shl;
  logic [SB-1:0]    w_sh;
  logic [REFRESH_BITS-1:0] r_ref;
  logic [DB-1:0]    w_idx;
  logic [3:0]       w_nib;

  assign w_acc_ok = in_valid && in_ready;

`ifdef ALU_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t            r_state, w_next;
  logic [2*W-1:0]    r_mcand, r_acc;
  logic [W-1:0]      r_mplier;
  logic [SB:0]       r_cnt;

  assign w_is_mul = op == 3'b111;
  assign w_done   = r_state == S_MUL && r_cnt == '0;
  assign w_mres   = r_acc[W-1:0];
  assign w_mc     = |r_acc[2*W-1:W];

  // MUL FSM state register
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;

  // Next state: enter MUL on an accepted multiply, leave once all iterations are done
  always_comb begin
    in_ready = r_state == S_IDLE;
    w_next   = r_state == S_IDLE ? (w_acc_ok && w_is_mul ? S_MUL : S_IDLE)
                                 : (r_cnt == '0 ? S_IDLE : S_MUL);
  end

  // Shift-add multiplier: one partial product per cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_acc_ok && w_is_mul) begin
      r_mcand  <= {{W{1'b0}}, a};
      r_mplier <= b;
      r_acc    <= '0;
      r_cnt    <= (SB+1)'(W);
    end else if (r_state == S_MUL && r_cnt != '0) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - 1'b1;
    end
`else
  assign in_ready = 1'b1;
  assign w_is_mul = 1'b0;
  assign w_done   = 1'b0;
  assign w_mres   = '0;
  assign w_mc     = 1'b0;
`endif

  // Capture operands of accepted single-cycle ops; later input changes are ignored
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_v  <= 1'b0;
      r_a  <= '0;
      r_b  <= '0;
      r_op <= '0;
    end else begin
      r_v <= w_acc_ok && !w_is_mul;
      if (w_acc_ok) begin
        r_a  <= a;
        r_b  <= b;
        r_op <= op;
      end
    end

  // Single-cycle ALU on captured operands; op 111 here yields zero (multiplier absent or bypassed)
  always_comb begin
    w_bb  = r_op == 3'b001 ? ~r_b : r_b;
    w_sum = {1'b0, r_a} + {1'b0, w_bb} + {{W{1'b0}}, r_op == 3'b001};
    w_sh  = r_b[SB-1:0];
    w_shl = {1'b0, r_a} << w_sh;
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (r_op)
      3'b000, 3'b001: begin
        w_res = w_sum[W-1:0];
        w_c   = w_sum[W];
        w_v   = (r_a[W-1] == w_bb[W-1]) && (w_sum[W-1] != r_a[W-1]);
      end
      3'b010: w_res = r_a & r_b;
      3'b011: w_res = r_a | r_b;
      3'b100: w_res = r_a ^ r_b;
      3'b101: w_res = {{(W-1){1'b0}}, $signed(r_a) < $signed(r_b)};
      3'b110: begin
        w_res = w_shl[W-1:0];
        w_c   = (w_sh != '0) && w_shl[W];
      end
      default: ;
    endcase
  end

  // Result/flags register with one-cycle completion pulse
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else begin
      out_valid <= r_v || w_done;
      if (w_done) begin
        result <= w_mres;
        flags  <= {w_mres[W-1], w_mres == '0, w_mc, 1'b0};
      end else if (r_v) begin
        result <= w_res;
        flags  <= {w_res[W-1], w_res == '0, w_c, w_v};
      end
    end

  // Free-running refresh counter; its top bits pick the displayed digit
  always_ff @(posedge clk or posedge reset)
    if (reset) r_ref <= '0;
    else       r_ref <= r_ref + 1'b1;

  // Digit select, hex glyph and decimal point (lit on the top digit when negative)
  always_comb begin
    w_idx = r_ref[REFRESH_BITS-1 -: DB];
    w_nib = result[w_idx*4 +: 4];
    an    = ~(ND'(1) << w_idx);
    dp    = !(w_idx == DB'(ND-1) && flags[3]);
    case (w_nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0001100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
  end
endmodule

// File: tb/tb_alu_pipe_disp.sv
// tb_alu_pipe_disp: randomized scoreboard bench for alu_pipe_disp (MUL expectations follow ALU_MUL_EN)
module tb_alu_pipe_disp;
  localparam int W = 8;
`ifdef ALU_MUL_EN
  localparam int MLAT = W + 1;
  localparam bit MUL_ON = 1'b1;
`else
  localparam int MLAT = 1;
  localparam bit MUL_ON = 1'b0;
`endif

  logic       clk = 1'b0, reset = 1'b1, in_valid = 1'b0;
  logic [2:0] op = '0;
  logic [7:0] a = '0, b = '0;
  logic       in_ready, out_valid, dp;
  logic [7:0] result;
  logic [3:0] flags;
  logic [6:0] seg;
  logic [1:0] an;

  alu_pipe_disp #(.W(W), .REFRESH_BITS(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .result(result),
    .flags(flags), .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  typedef struct {logic [7:0] r; logic [3:0] f; int due;} exp_t;
  exp_t q[$];
  int cyc = 0, busy_until = 0, n_tests = 0, n_fail = 0;
  logic [3:0] ref_cnt;
  logic [7:0] shown_r = '0;
  logic [3:0] shown_f = '0;
  logic [6:0] glyph [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or posedge reset)
    if (reset) ref_cnt <= '0;
    else       ref_cnt <= ref_cnt + 1'b1;

  task automatic chk(input string nm, input int act, input int ex);
    n_tests++;
    if (act != ex) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, ex, cyc);
    end
  endtask

  // Reference model: {N,Z,C,V, result} from plain integer arithmetic
  function automatic logic [11:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int sx, sy, s, r, c, v, sh;
    sx = (x > 127) ? int'(x) - 256 : int'(x);
    sy = (y > 127) ? int'(y) - 256 : int'(y);
    r = 0; c = 0; v = 0;
    case (o)
      3'd0: begin s = x + y; r = s % 256; c = s / 256; v = (sx + sy > 127 || sx + sy < -128) ? 1 : 0; end
      3'd1: begin s = x + (255 - y) + 1; r = s % 256; c = s / 256; v = (sx - sy > 127 || sx - sy < -128) ? 1 : 0; end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = (sx < sy) ? 1 : 0;
      3'd6: begin sh = y % 8; r = (int'(x) << sh) % 256; c = (sh != 0) ? (int'(x) >> (8 - sh)) & 1 : 0; end
      default: if (MUL_ON) begin s = x * y; r = s % 256; c = (s > 255) ? 1 : 0; end
    endcase
    return {r[7], r == 0, c[0], v[0], r[7:0]};
  endfunction

  task automatic drive(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    logic [11:0] m;
    int e;
    @(negedge clk); #1;
    in_valid = 1'b1; op = o; a = x; b = y;
    while (cyc < busy_until) begin @(negedge clk); #1; end
    m = model(o, x, y);
    e = cyc + 1;
    q.push_back('{m[7:0], m[11:8], e + ((o == 3'd7) ? MLAT : 1)});
    if (o == 3'd7 && MUL_ON) busy_until = e + W + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk); #1;
    in_valid = 1'b0; reset = 1'b1;
    q.delete(); busy_until = 0; shown_r = '0; shown_f = '0;
    repeat (n) @(negedge clk);
    #1 reset = 1'b0;
  endtask

  // Monitor: pop expected results on out_valid, check holding, handshake and display
  always @(negedge clk) begin
    exp_t e;
    logic idx;
    if (reset) begin
      chk("reset_out_valid", out_valid, 0);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_result", result, 0);
      chk("reset_flags", flags, 0);
    end else begin
      if (q.size() != 0 && q[0].due < cyc) begin
        n_tests++; n_fail++;
        $display("FAIL missing_out_valid: got none, required by cycle %0d (now %0d)", q[0].due, cyc);
        e = q.pop_front(); shown_r = e.r; shown_f = e.f;
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_out_valid: got pulse with result 0x%0h, required none (cycle %0d)", result, cyc);
        end else begin
          e = q.pop_front();
          chk("result", result, e.r);
          chk("flags", flags, e.f);
          chk("latency_cycle", cyc, e.due);
          shown_r = e.r; shown_f = e.f;
        end
      end
      chk("held_result", result, shown_r);
      chk("held_flags", flags, shown_f);
      chk("in_ready", in_ready, (cyc >= busy_until) ? 1 : 0);
    end
    idx = ref_cnt[3];
    chk("an", an, idx ? 1 : 2);
    chk("seg", seg, glyph[idx ? shown_r[7:4] : shown_r[3:0]]);
    chk("dp", dp, (idx && shown_f[3]) ? 0 : 1);
  end

  initial begin
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    drive(3'd0, 8'h7F, 8'h01);
    idle(2);
    drive(3'd1, 8'h05, 8'h05);
    drive(3'd5, 8'hFF, 8'h01);
    drive(3'd6, 8'h81, 8'h01);
    drive(3'd6, 8'h81, 8'h00);
    drive(3'd2, 8'hF0, 8'h3C);
    idle(3);
    drive(3'd7, 8'h10, 8'h11);
    drive(3'd0, 8'h03, 8'h04);
    idle(12);
    drive(3'd7, 8'h23, 8'h45);
    idle(3);
    do_reset(2);
    idle(2);
    drive(3'd0, 8'h3C, 8'h00);
    idle(40);
    drive(3'd0, 8'h80, 8'h05);
    idle(34);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      else drive(3'($urandom), 8'($urandom), 8'($urandom));
    end
    idle(2);
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: got %0d results outstanding, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
